// File: rtl/vga_timing_out_if.sv
// ============================================================================
// Module      : vga_timing_out_if
// Description : Scan-coordinate, colour-return and VGA pin bundle for
//               vga_timing_out. Adds vblank when VGA_TIMING_VBLANK_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_timing_out_if;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic [14:0] color;
    logic        line_start;
    logic        frame_start;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_de;
    logic [4:0]  vga_r;
    logic [4:0]  vga_g;
    logic [4:0]  vga_b;
`ifdef VGA_TIMING_VBLANK_EN
    logic        vblank;
`endif

    modport master (
`ifdef VGA_TIMING_VBLANK_EN
        output vblank,
`endif
        output sx, sy, line_start, frame_start,
        output vga_hsync, vga_vsync, vga_de, vga_r, vga_g, vga_b,
        input  color
    );

    modport slave (
`ifdef VGA_TIMING_VBLANK_EN
        input  vblank,
`endif
        input  sx, sy, line_start, frame_start,
        input  vga_hsync, vga_vsync, vga_de, vga_r, vga_g, vga_b,
        output color
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing_out.sv
// ============================================================================
// Module      : vga_timing_out
// Description : Free-running VGA timing generator with a delayed sync/de
//               line and registered colour output. Optional macro
//               VGA_TIMING_VBLANK_EN adds a registered vblank output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_out #(
    parameter int   H_ACTIVE   = 800,
    parameter int   H_FP       = 40,
    parameter int   H_SYNC     = 48,
    parameter int   H_BP       = 40,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 13,
    parameter int   V_SYNC     = 3,
    parameter int   V_BP       = 29,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   PIPE_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vga_timing_out_if.master      vga
);

    localparam int C_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int C_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int C_HS_START = H_ACTIVE + H_FP;
    localparam int C_HS_END   = C_HS_START + H_SYNC;
    localparam int C_VS_START = V_ACTIVE + V_FP;
    localparam int C_VS_END   = C_VS_START + V_SYNC;

    logic [9:0] r_sx;
    logic [9:0] r_sy;
    logic [9:0] w_sx_next;
    logic [9:0] w_sy_next;
    logic       w_sx_last;
    logic       w_sy_last;

    logic       w_hs_raw;
    logic       w_vs_raw;
    logic       w_de_raw;
    logic       w_de_pre;

    logic [PIPE_DELAY-1:0] r_hs_dly;
    logic [PIPE_DELAY-1:0] r_vs_dly;
    logic [PIPE_DELAY-1:0] r_de_dly;

    logic [4:0] r_r;
    logic [4:0] r_g;
    logic [4:0] r_b;

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    assign w_sx_last = (r_sx == 10'(C_H_TOTAL - 1));
    assign w_sy_last = (r_sy == 10'(C_V_TOTAL - 1));

    always_comb begin
        w_sx_next = r_sx + 10'd1;
        w_sy_next = r_sy;
        if (w_sx_last) begin
            w_sx_next = '0;
            w_sy_next = w_sy_last ? '0 : (r_sy + 10'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sx <= '0;
            r_sy <= '0;
        end else begin
            r_sx <= w_sx_next;
            r_sy <= w_sy_next;
        end
    end

    // Raw timing flags are kept active-high; polarity is applied at the pins.
    assign w_hs_raw = (r_sx >= 10'(C_HS_START)) && (r_sx < 10'(C_HS_END));
    assign w_vs_raw = (r_sy >= 10'(C_VS_START)) && (r_sy < 10'(C_VS_END));
    assign w_de_raw = (r_sx < 10'(H_ACTIVE)) && (r_sy < 10'(V_ACTIVE));

    // ------------------------------------------------------------------
    // Sync / data-enable delay line
    // ------------------------------------------------------------------
    generate
        if (PIPE_DELAY == 1) begin : g_dly_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hs_dly <= '0;
                    r_vs_dly <= '0;
                    r_de_dly <= '0;
                end else begin
                    r_hs_dly <= w_hs_raw;
                    r_vs_dly <= w_vs_raw;
                    r_de_dly <= w_de_raw;
                end
            end
            assign w_de_pre = w_de_raw;
        end else begin : g_dly_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hs_dly <= '0;
                    r_vs_dly <= '0;
                    r_de_dly <= '0;
                end else begin
                    r_hs_dly <= {r_hs_dly[PIPE_DELAY-2:0], w_hs_raw};
                    r_vs_dly <= {r_vs_dly[PIPE_DELAY-2:0], w_vs_raw};
                    r_de_dly <= {r_de_dly[PIPE_DELAY-2:0], w_de_raw};
                end
            end
            // de entering the last stage on this edge gates the colour sample
            assign w_de_pre = r_de_dly[PIPE_DELAY-2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Colour output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end else if (w_de_pre) begin
            r_r <= vga.color[14:10];
            r_g <= vga.color[9:5];
            r_b <= vga.color[4:0];
        end else begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end
    end

`ifdef VGA_TIMING_VBLANK_EN
    logic r_vblank;

    // Computed from the next line so vblank tracks sy on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vblank <= 1'b0;
        end else begin
            r_vblank <= (w_sy_next >= 10'(V_ACTIVE));
        end
    end

    assign vga.vblank = r_vblank;
`endif

    assign vga.sx          = r_sx;
    assign vga.sy          = r_sy;
    assign vga.line_start  = (r_sx == 10'd0);
    assign vga.frame_start = (r_sx == 10'd0) && (r_sy == 10'd0);
    assign vga.vga_hsync   = r_hs_dly[PIPE_DELAY-1] ? SYNC_POL : ~SYNC_POL;
    assign vga.vga_vsync   = r_vs_dly[PIPE_DELAY-1] ? SYNC_POL : ~SYNC_POL;
    assign vga.vga_de      = r_de_dly[PIPE_DELAY-1];
    assign vga.vga_r       = r_r;
    assign vga.vga_g       = r_g;
    assign vga.vga_b       = r_b;

endmodule

`default_nettype wire
